// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access-size encodings,
// FSM state type and the lane-offset helper used by the datapath.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Byte lane actually used by an access: misaligned low bits are dropped so a
  // half always sits on lanes {0,1}/{2,3} and a word on all four lanes.
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return {addr_lo[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a core (master) and dmem_ctrl (slave).
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] wdata;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        fault;

  modport master (
    output req, we, addr, size, ld_unsigned, wdata,
    input  busy, ready, rdata, fault
  );

  modport slave (
    input  req, we, addr, size, ld_unsigned, wdata,
    output busy, ready, rdata, fault
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering shared by stores and loads: lane enables plus data
// replication for stores, shift-to-bit-0 plus sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  assign shifted = rword_i >> {offset_i, 3'b000};

  // Decode size into lane enables, replicated store data and extended load data.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~ld_unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << offset_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~ld_unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        rdata_o = shifted;
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data-memory controller with a fixed-latency request/ready
// handshake. Optional build macro DMEM_FAULT_CHECK_EN turns misaligned and
// out-of-range accesses into faults; without it they are aligned down / wrapped.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus_io
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          resp;
  logic          fault_c;
  logic [AW-1:0] idx;
  logic [1:0]    offset;
  logic [3:0]    be;
  logic [31:0]   wdata_al;
  logic [31:0]   ld_data;
  logic [31:0]   resp_data;

  // Requests are only taken in IDLE; anything seen while busy is dropped.
  assign accept = (state_q == StIdle) && bus_io.req;
  assign resp   = (state_q == StResp);
  assign idx    = addr_q[AW+1:2];
  assign offset = lane_offset(size_q, addr_q[1:0]);

`ifdef DMEM_FAULT_CHECK_EN
  logic misalign;
  logic out_of_range;
  assign misalign     = ((size_q == SZ_HALF) && addr_q[0]) ||
                        ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
  assign out_of_range = |addr_q[31:AW+2];
  assign fault_c      = (size_q == SZ_ILL) || misalign || out_of_range;
`else
  // High address bits are intentionally ignored: accesses wrap modulo the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:AW+2];
  assign fault_c        = (size_q == SZ_ILL);
`endif

  dmem_lane_align u_lane_align (
    .size_i        (size_q),
    .offset_i      (offset),
    .ld_unsigned_i (uns_q),
    .wdata_i       (wdata_q),
    .rword_i       (mem_q[idx]),
    .be_o          (be),
    .wdata_o       (wdata_al),
    .rdata_o       (ld_data)
  );

  assign resp_data = (we_q || fault_c) ? 32'h0 : ld_data;

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: IDLE -> WAIT (skipped when WAIT_STATES is 0) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.req) begin
          state_d = (WAIT_STATES == 0) ? StResp : StWait;
          cnt_d   = WAIT_LOAD;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs; rdata is live during RESP and holds afterwards.
  always_comb begin
    bus_io.busy  = (state_q != StIdle);
    bus_io.ready = resp;
    bus_io.fault = resp && fault_c;
    bus_io.rdata = resp ? resp_data : rdata_q;
  end

  // Capture the request on accept and remember the last response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= bus_io.we;
        addr_q  <= bus_io.addr;
        size_q  <= bus_io.size;
        uns_q   <= bus_io.ld_unsigned;
        wdata_q <= bus_io.wdata;
      end
      if (resp) begin
        rdata_q <= resp_data;
      end
    end
  end

  // Store commits on the edge that ends RESP; the array is never reset.
  always_ff @(posedge clk) begin
    if (resp && we_q && !fault_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_al[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with two wait states, one with none.
module tb_dmem_ctrl;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  dmem_if if2 ();
  dmem_if if0 ();

  dmem_ctrl #(
    .DEPTH_WORDS (256),
    .WAIT_STATES (2)
  ) u_dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (if2)
  );

  dmem_ctrl #(
    .DEPTH_WORDS (256),
    .WAIT_STATES (0)
  ) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // One access on the two-wait-state instance; lat counts cycles from the accept edge.
  task automatic access2(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rd, output logic flt);
    @(negedge clk);
    if2.we = we; if2.addr = addr; if2.size = size; if2.ld_unsigned = uns; if2.wdata = wdata;
    if2.req = 1'b1;
    @(posedge clk); #1;
    if2.req = 1'b0;
    lat = 1;
    while (if2.ready !== 1'b1 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = if2.rdata;
    flt = if2.fault;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total_cnt++; if (if2.busy !== 1'b0) $display("FAIL rst_busy2: got %b want 0", if2.busy); else pass_cnt++;
    total_cnt++; if (if2.ready !== 1'b0) $display("FAIL rst_ready2: got %b want 0", if2.ready); else pass_cnt++;
    total_cnt++; if (if2.fault !== 1'b0) $display("FAIL rst_fault2: got %b want 0", if2.fault); else pass_cnt++;
    total_cnt++; if (if2.rdata !== 32'h0) $display("FAIL rst_rdata2: got %h want 0", if2.rdata); else pass_cnt++;
    total_cnt++; if (if0.busy !== 1'b0) $display("FAIL rst_busy0: got %b want 0", if0.busy); else pass_cnt++;
    total_cnt++; if (if0.rdata !== 32'h0) $display("FAIL rst_rdata0: got %h want 0", if0.rdata); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    int lat; logic [31:0] rd; logic flt;
    access2(1'b1, 32'h40, 2'b10, 1'b0, 32'hDEADBEEF, lat, rd, flt);
    total_cnt++; if (lat != 3) $display("FAIL store_latency: got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL store_rdata: got %h want 0", rd); else pass_cnt++;
    total_cnt++; if (flt !== 1'b0) $display("FAIL store_fault: got %b want 0", flt); else pass_cnt++;
    access2(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (lat != 3) $display("FAIL load_latency: got %0d want 3", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL load_word: got %h want deadbeef", rd); else pass_cnt++;
    total_cnt++; if (if2.ready !== 1'b0) $display("FAIL ready_pulse: got %b want 0", if2.ready); else pass_cnt++;
    total_cnt++; if (if2.rdata !== 32'hDEADBEEF) $display("FAIL rdata_hold: got %h want deadbeef", if2.rdata); else pass_cnt++;
  endtask

  task automatic test_extension();
    int lat; logic [31:0] rd; logic flt;
    access2(1'b1, 32'h10, 2'b10, 1'b0, 32'h80FF7F01, lat, rd, flt);
    access2(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (rd !== 32'hFFFFFF80) $display("FAIL byte13_signed: got %h want ffffff80", rd); else pass_cnt++;
    access2(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, lat, rd, flt);
    total_cnt++; if (rd !== 32'h00000080) $display("FAIL byte13_unsigned: got %h want 00000080", rd); else pass_cnt++;
    access2(1'b0, 32'h10, 2'b01, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (rd !== 32'h00007F01) $display("FAIL half10_signed: got %h want 00007f01", rd); else pass_cnt++;
    access2(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (rd !== 32'hFFFF80FF) $display("FAIL half12_signed: got %h want ffff80ff", rd); else pass_cnt++;
    access2(1'b0, 32'h12, 2'b01, 1'b1, 32'h0, lat, rd, flt);
    total_cnt++; if (rd !== 32'h000080FF) $display("FAIL half12_unsigned: got %h want 000080ff", rd); else pass_cnt++;
    access2(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (rd !== 32'h0000007F) $display("FAIL byte11_signed: got %h want 0000007f", rd); else pass_cnt++;
  endtask

  task automatic test_partial_store();
    int lat; logic [31:0] rd; logic flt;
    access2(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, lat, rd, flt);
    access2(1'b1, 32'h21, 2'b00, 1'b0, 32'h000000AA, lat, rd, flt);
    access2(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (rd !== 32'h1122AA44) $display("FAIL byte_store: got %h want 1122aa44", rd); else pass_cnt++;
    access2(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000BEEF, lat, rd, flt);
    access2(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (rd !== 32'hBEEFAA44) $display("FAIL half_store: got %h want beefaa44", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic exp;
    @(negedge clk);
    if0.we = 1'b0; if0.addr = 32'h0; if0.size = 2'b10; if0.ld_unsigned = 1'b0; if0.wdata = 32'h0;
    if0.req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      exp = ((i % 2) == 0);
      total_cnt++;
      if (if0.ready !== exp) $display("FAIL b2b_ready[%0d]: got %b want %b", i, if0.ready, exp);
      else pass_cnt++;
      total_cnt++;
      if (if0.busy !== exp) $display("FAIL b2b_busy[%0d]: got %b want %b", i, if0.busy, exp);
      else pass_cnt++;
    end
    if0.req = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int readies;
    @(negedge clk);
    if2.we = 1'b0; if2.addr = 32'h40; if2.size = 2'b10; if2.ld_unsigned = 1'b0; if2.wdata = 32'h0;
    if2.req = 1'b1;
    @(posedge clk); #1;
    if2.req = 1'b0;
    @(negedge clk);
    total_cnt++; if (if2.busy !== 1'b1) $display("FAIL busy_in_wait: got %b want 1", if2.busy); else pass_cnt++;
    if2.req = 1'b1;
    readies = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if2.req = 1'b0;
      if (if2.ready === 1'b1) readies++;
    end
    total_cnt++; if (readies != 1) $display("FAIL busy_req_ignored: got %0d readies want 1", readies); else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [31:0] rd; logic flt; int bad;
    access2(1'b1, 32'h30, 2'b10, 1'b0, 32'h55667788, lat, rd, flt);
    access2(1'b0, 32'h30, 2'b10, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (rd !== 32'h55667788) $display("FAIL pre_reset_load: got %h want 55667788", rd); else pass_cnt++;
    @(negedge clk);
    if2.we = 1'b1; if2.addr = 32'h30; if2.size = 2'b10; if2.wdata = 32'h0BADF00D;
    if2.req = 1'b1;
    @(posedge clk); #1;
    if2.req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (if2.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", if2.busy); else pass_cnt++;
    total_cnt++; if (if2.ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", if2.ready); else pass_cnt++;
    total_cnt++; if (if2.rdata !== 32'h0) $display("FAIL midrst_rdata: got %h want 0", if2.rdata); else pass_cnt++;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (if2.ready !== 1'b0 || if2.busy !== 1'b0) bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (if2.ready !== 1'b0 || if2.busy !== 1'b0) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL midrst_no_ready: got %0d bad cycles want 0", bad); else pass_cnt++;
    access2(1'b0, 32'h30, 2'b10, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (rd !== 32'h55667788) $display("FAIL midrst_no_write: got %h want 55667788", rd); else pass_cnt++;
  endtask

  task automatic test_fault();
    int lat; logic [31:0] rd; logic flt;
    access2(1'b0, 32'h42, 2'b10, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (lat != 3) $display("FAIL mis_latency: got %0d want 3", lat); else pass_cnt++;
`ifdef DMEM_FAULT_CHECK_EN
    total_cnt++; if (flt !== 1'b1) $display("FAIL mis_fault: got %b want 1", flt); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL mis_rdata: got %h want 0", rd); else pass_cnt++;
`else
    total_cnt++; if (flt !== 1'b0) $display("FAIL mis_fault: got %b want 0", flt); else pass_cnt++;
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL mis_rdata: got %h want deadbeef", rd); else pass_cnt++;
`endif
    access2(1'b0, 32'h440, 2'b10, 1'b0, 32'h0, lat, rd, flt);
`ifdef DMEM_FAULT_CHECK_EN
    total_cnt++; if (flt !== 1'b1) $display("FAIL oor_fault: got %b want 1", flt); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL oor_rdata: got %h want 0", rd); else pass_cnt++;
`else
    total_cnt++; if (flt !== 1'b0) $display("FAIL oor_fault: got %b want 0", flt); else pass_cnt++;
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL oor_rdata: got %h want deadbeef", rd); else pass_cnt++;
`endif
    access2(1'b0, 32'h40, 2'b11, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (flt !== 1'b1) $display("FAIL ill_load_fault: got %b want 1", flt); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL ill_load_rdata: got %h want 0", rd); else pass_cnt++;
    access2(1'b1, 32'h40, 2'b11, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (flt !== 1'b1) $display("FAIL ill_store_fault: got %b want 1", flt); else pass_cnt++;
    access2(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, lat, rd, flt);
    total_cnt++; if (flt !== 1'b0) $display("FAIL post_ill_fault: got %b want 0", flt); else pass_cnt++;
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL ill_store_suppressed: got %h want deadbeef", rd); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    if2.req = 1'b0; if2.we = 1'b0; if2.addr = 32'h0; if2.size = 2'b00;
    if2.ld_unsigned = 1'b0; if2.wdata = 32'h0;
    if0.req = 1'b0; if0.we = 1'b0; if0.addr = 32'h0; if0.size = 2'b00;
    if0.ld_unsigned = 1'b0; if0.wdata = 32'h0;
    test_reset();
    test_word_store_load();
    test_extension();
    test_partial_store();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_access();
    test_fault();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
